// File: rtl/spi_flash_responder.sv
// Single-bit SPI NOR flash emulator: serves READ, FAST_READ and JEDEC ID from a
// byte-wide memory read port, with flash_csb/flash_clk/flash_io0 oversampled by clk.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flash_csb,
    input  logic              flash_clk,
    input  logic              flash_io0_in,
    output logic              flash_io1_out,
    output logic              flash_io1_iosel,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              active
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic [1:0] csb_sync, sclk_sync, io0_sync;
    logic       csb_prev, sclk_prev;
    logic       csb_s, sclk_s, io0_s;
    logic       csb_rise, csb_fall, sclk_rise, sclk_fall;

    logic [4:0]        bit_cnt;
    logic              dummy;
    logic [6:0]        cmd_sh;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr, addr_shifted;
    logic [7:0]        out_sh, next_byte, id_byte;
    logic [1:0]        id_idx;
    logic              rd_pending, first_load;
    logic              enter_data, shift_out;

    // Synchronizers carry no reset so a csb already low at reset release is seen as low.
    always_ff @(posedge clk) begin
        csb_sync  <= {csb_sync[0], flash_csb};
        sclk_sync <= {sclk_sync[0], flash_clk};
        io0_sync  <= {io0_sync[0], flash_io0_in};
    end

    assign csb_s  = csb_sync[1];
    assign sclk_s = sclk_sync[1];
    assign io0_s  = io0_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            csb_prev  <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            csb_prev  <= csb_s;
            sclk_prev <= sclk_s;
        end
    end

    // A csb rise masks any coincident flash_clk edge.
    assign csb_rise  = csb_s & ~csb_prev;
    assign csb_fall  = ~csb_s & csb_prev;
    assign sclk_rise = sclk_s & ~sclk_prev & ~csb_rise;
    assign sclk_fall = ~sclk_s & sclk_prev & ~csb_rise;

    assign opcode       = {cmd_sh, io0_s};
    assign addr_shifted = {addr[ADDR_W-2:0], io0_s};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (csb_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (csb_fall) state_next = CMD;
                CMD: begin
                    if (sclk_rise && bit_cnt == 5'd7) begin
                        case (opcode)
                            8'h03, 8'h0B: state_next = ADDR;
                            8'h9F:        state_next = ID;
                            default:      state_next = IGNORE;
                        endcase
                    end
                end
                ADDR:  if (sclk_rise && bit_cnt == 5'd23) state_next = dummy ? DUMMY : DATA;
                DUMMY: if (sclk_rise && bit_cnt == 5'd7) state_next = DATA;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        case (id_idx)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    assign enter_data = (state_next == DATA) && (state != DATA);
    assign shift_out  = sclk_fall && (state == DATA || state == ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_io1_out   <= 1'b0;
            flash_io1_iosel <= 1'b0;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            active          <= 1'b0;
            bit_cnt         <= '0;
            dummy           <= 1'b0;
            cmd_sh          <= '0;
            addr            <= '0;
            out_sh          <= '0;
            next_byte       <= '0;
            id_idx          <= '0;
            rd_pending      <= 1'b0;
            first_load      <= 1'b0;
        end else begin
            active     <= ~csb_s;
            mem_rd     <= 1'b0;
            rd_pending <= mem_rd;
            if (csb_rise) begin
                bit_cnt         <= '0;
                dummy           <= 1'b0;
                flash_io1_iosel <= 1'b0;
                flash_io1_out   <= 1'b0;
                rd_pending      <= 1'b0;
                first_load      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (csb_fall) begin
                            bit_cnt <= '0;
                            dummy   <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sh  <= opcode[6:0];
                            bit_cnt <= (state_next != CMD) ? 5'd0 : bit_cnt + 5'd1;
                            if (state_next == ADDR) dummy <= (opcode == 8'h0B);
                            if (state_next == ID) begin
                                out_sh <= JEDEC_ID[23:16];
                                id_idx <= 2'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr    <= addr_shifted;
                            bit_cnt <= (state_next != ADDR) ? 5'd0 : bit_cnt + 5'd1;
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise) bit_cnt <= (state_next != DUMMY) ? 5'd0 : bit_cnt + 5'd1;
                    end
                    default: ;
                endcase

                if (enter_data) begin
                    mem_rd     <= 1'b1;
                    mem_addr   <= (state == ADDR) ? addr_shifted : addr;
                    first_load <= 1'b1;
                end

                // Each byte's MSB fall prefetches the following byte, eight falls ahead of need.
                if (shift_out) begin
                    flash_io1_iosel <= 1'b1;
                    flash_io1_out   <= out_sh[7];
                    if (bit_cnt[2:0] == 3'd7) begin
                        bit_cnt <= '0;
                        if (state == ID) begin
                            out_sh <= id_byte;
                            if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end else begin
                            out_sh <= next_byte;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        out_sh  <= {out_sh[6:0], 1'b0};
                    end
                    if (state == DATA && bit_cnt[2:0] == 3'd0) begin
                        addr     <= addr + ADDR_W'(1);
                        mem_addr <= addr + ADDR_W'(1);
                        mem_rd   <= 1'b1;
                    end
                end

                if (rd_pending) begin
                    if (first_load) begin
                        out_sh     <= mem_rdata;
                        first_load <= 1'b0;
                    end else begin
                        next_byte  <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: table of flash transactions plus
// hand-written abort and reset-during-read sequences.
`timescale 1ns/1ps
module tb_spi_flash_responder;

    localparam int ADDR_W = 24;

    typedef struct {
        logic [7:0]  opcode;
        bit          has_addr;
        bit          dummy;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp_data;
        bit          exp_oe;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flash_csb = 1'b1;
    logic              flash_clk = 1'b0;
    logic              flash_io0_in = 1'b0;
    logic              flash_io1_out, flash_io1_iosel, mem_rd, active;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;

    int          checks = 0;
    int          errors = 0;
    int          rd_width_err = 0;
    logic        mem_rd_seen = 1'b0;
    logic [23:0] rd_log[$];

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4016)) dut (
        .clk            (clk),
        .reset          (reset),
        .flash_csb      (flash_csb),
        .flash_clk      (flash_clk),
        .flash_io0_in   (flash_io0_in),
        .flash_io1_out  (flash_io1_out),
        .flash_io1_iosel(flash_io1_iosel),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .active         (active)
    );

    always #31 clk = ~clk;

    // Backing memory holds memory[i] = i[7:0], one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[7:0];
    end

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_log.push_back(mem_addr);
            if (mem_rd_seen) rd_width_err++;
        end
        mem_rd_seen = mem_rd;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One mode-0 bit: set MOSI, rise after 4 clk (sampling MISO just before), fall after 4 more.
    task automatic spi_bit(input logic mosi, input logic last, output logic miso, output logic oe);
        flash_io0_in = mosi;
        repeat (4) @(negedge clk);
        miso = flash_io1_out;
        oe   = flash_io1_iosel;
        flash_clk = 1'b1;
        repeat (4) @(negedge clk);
        flash_clk = 1'b0;
        if (last) flash_csb = 1'b1;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic last, output logic [7:0] rx,
                            output logic oe_all, output logic oe_any);
        logic m, o;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], last && (i == 0), m, o);
            rx[i]  = m;
            oe_all = oe_all & o;
            oe_any = oe_any | o;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [7:0]  rx, exp_byte;
        logic [23:0] exp_addr;
        logic        oa, oy, pre_oe, data_oe_all, data_oe_any;
        int          n_rd;
        pre_oe = 1'b0;
        data_oe_all = 1'b1;
        data_oe_any = 1'b0;
        rd_log.delete();
        flash_csb = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput($sformatf("v%0d active", idx), 32'(active), 32'd1);
        spi_byte(v.opcode, 1'b0, rx, oa, oy);
        pre_oe = pre_oe | oy;
        if (v.has_addr) begin
            for (int b = 2; b >= 0; b--) begin
                spi_byte(v.addr[8*b +: 8], 1'b0, rx, oa, oy);
                pre_oe = pre_oe | oy;
            end
        end
        if (v.dummy) begin
            spi_byte(8'h00, 1'b0, rx, oa, oy);
            pre_oe = pre_oe | oy;
        end
        for (int b = 0; b < v.nbytes; b++) begin
            spi_byte(8'h00, b == v.nbytes - 1, rx, oa, oy);
            data_oe_all = data_oe_all & oa;
            data_oe_any = data_oe_any | oy;
            exp_byte = v.exp_data[31-8*b -: 8];
            if (v.exp_oe) checkOutput($sformatf("v%0d byte%0d", idx, b), 32'(rx), 32'(exp_byte));
        end
        repeat (8) @(negedge clk);
        checkOutput($sformatf("v%0d iosel before data", idx), 32'(pre_oe), 32'd0);
        if (v.exp_oe) checkOutput($sformatf("v%0d iosel during data", idx), 32'(data_oe_all), 32'd1);
        else          checkOutput($sformatf("v%0d iosel during ignore", idx), 32'(data_oe_any), 32'd0);
        checkOutput($sformatf("v%0d iosel after csb", idx), 32'(flash_io1_iosel), 32'd0);
        checkOutput($sformatf("v%0d active after csb", idx), 32'(active), 32'd0);
        n_rd = rd_log.size();
        if (v.has_addr) begin
            checkOutput($sformatf("v%0d mem_rd count in range (%0d)", idx, n_rd),
                        32'(n_rd >= v.nbytes && n_rd <= v.nbytes + 1), 32'd1);
            for (int k = 0; k < v.nbytes && k < n_rd; k++) begin
                exp_addr = v.addr + 24'(k);
                checkOutput($sformatf("v%0d mem_addr%0d", idx, k), 32'(rd_log[k]), 32'(exp_addr));
            end
        end else begin
            checkOutput($sformatf("v%0d mem_rd count", idx), 32'(n_rd), 32'd0);
        end
        checkOutput($sformatf("v%0d mem_rd width", idx), 32'(rd_width_err), 32'd0);
    endtask

    initial begin
        vec_t       vecs[6];
        vec_t       hv;
        logic [7:0] rx;
        logic       m, o, oa, oy, oe_acc;

        vecs[0] = '{8'h9F, 1'b0, 1'b0, 24'h000000, 4, 32'hEF401600, 1'b1};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 24'h000100, 4, 32'h00010203, 1'b1};
        vecs[2] = '{8'h0B, 1'b1, 1'b1, 24'h000010, 2, 32'h10110000, 1'b1};
        vecs[3] = '{8'h03, 1'b1, 1'b0, 24'hFFFFFE, 4, 32'hFEFF0001, 1'b1};
        vecs[4] = '{8'h05, 1'b0, 1'b0, 24'h000000, 2, 32'h00000000, 1'b0};
        vecs[5] = '{8'h03, 1'b1, 1'b0, 24'h000020, 1, 32'h20000000, 1'b1};

        repeat (5) @(negedge clk);
        checkOutput("reset io1_out", 32'(flash_io1_out), 32'd0);
        checkOutput("reset iosel", 32'(flash_io1_iosel), 32'd0);
        checkOutput("reset mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset active", 32'(active), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idle active", 32'(active), 32'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Abort a READ after 12 address bits, then a fresh READ must work.
        rd_log.delete();
        flash_csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h03, 1'b0, rx, oa, oy);
        oe_acc = oy;
        for (int i = 0; i < 12; i++) begin
            spi_bit(1'b1, 1'b0, m, o);
            oe_acc = oe_acc | o;
        end
        repeat (2) @(negedge clk);
        flash_csb = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort iosel", 32'(oe_acc | flash_io1_iosel), 32'd0);
        checkOutput("abort mem_rd count", 32'(rd_log.size()), 32'd0);
        hv = '{8'h03, 1'b1, 1'b0, 24'h000040, 1, 32'h40000000, 1'b1};
        applyStimulus(hv, 6);

        // Reset asserted during DATA; the still-low csb must then be ignored.
        flash_csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h03, 1'b0, rx, oa, oy);
        spi_byte(8'h00, 1'b0, rx, oa, oy);
        spi_byte(8'h00, 1'b0, rx, oa, oy);
        spi_byte(8'hFF, 1'b0, rx, oa, oy);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, m, o);
        repeat (3) @(negedge clk);
        checkOutput("pre-reset iosel", 32'(flash_io1_iosel), 32'd1);
        checkOutput("pre-reset io1_out", 32'(flash_io1_out), 32'd1);
        checkOutput("pre-reset mem_addr", 32'(mem_addr), 32'h000100);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid reset io1_out", 32'(flash_io1_out), 32'd0);
        checkOutput("mid reset iosel", 32'(flash_io1_iosel), 32'd0);
        checkOutput("mid reset mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("mid reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("mid reset active", 32'(active), 32'd0);
        reset = 1'b0;
        rd_log.delete();
        spi_byte(8'h03, 1'b0, rx, oa, oy);
        oe_acc = oy;
        spi_byte(8'h00, 1'b0, rx, oa, oy);
        oe_acc = oe_acc | oy;
        repeat (4) @(negedge clk);
        checkOutput("post-reset stale iosel", 32'(oe_acc), 32'd0);
        checkOutput("post-reset stale mem_rd count", 32'(rd_log.size()), 32'd0);
        flash_csb = 1'b1;
        repeat (8) @(negedge clk);
        hv = '{8'h03, 1'b1, 1'b0, 24'h000055, 1, 32'h55000000, 1'b1};
        applyStimulus(hv, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI target that emulates the subset of a serial NOR flash that the SoC's SPI flash controller uses in single-bit mode. It serves READ (0x03), FAST_READ (0x0B) and JEDEC ID (0x9F) from a byte-wide backing memory read port. It sits in simulation and FPGA-loopback builds on the far end of the flash_csb/flash_clk/flash_io0/flash_io1 lines, so the CPU boot path can be exercised without a physical flash. flash_clk is oversampled by the system clock.

## Interface
- ADDR_W, 24: byte address width presented on mem_addr; the address counter wraps at 2^ADDR_W.
- JEDEC_ID, 24'hEF4016: 3 ID bytes returned MSB-first for 0x9F.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flash_csb  input  1  chip select, active low; asynchronous to clk.
- flash_clk  input  1  SPI clock, mode 0; asynchronous to clk.
- flash_io0_in  input  1  controller-to-target data (MOSI).
- flash_io1_out  output  1  target-to-controller data (MISO).
- flash_io1_iosel  output  1  1 = drive flash_io1 pad, 0 = high-Z.
- mem_rd  output  1  one-cycle read strobe to the backing memory.
- mem_addr  output  ADDR_W  byte address, valid while mem_rd=1.
- mem_rdata  input  8  read data, valid exactly 1 clk after mem_rd.
- active  output  1  1 while flash_csb is (synchronized) low.

## Operation
- Synchronize flash_csb, flash_clk and flash_io0_in with 2-FF synchronizers.
- Rise and fall edges of flash_clk are 1-cycle pulses from comparing the synchronized value with its previous value.
- Bits are sampled on the rise pulse and shifted out on the fall pulse, MSB first.
- State machine states: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
- IDLE -> CMD on a synchronized csb fall. Bit counter = 0.
- CMD: shift in 8 bits. On the 8th rise, transition by opcode:
  - 0x03 -> ADDR.
  - 0x0B -> ADDR, with the dummy flag set.
  - 0x9F -> ID; load the shift register with JEDEC_ID[23:16].
  - any other opcode -> IGNORE.
- ADDR: shift in 24 bits into the address register; the upper bits beyond ADDR_W are discarded. On the 24th rise:
  - dummy flag set -> DUMMY;
  - otherwise -> DATA, issuing mem_rd on the next cycle.
- DUMMY: count 8 rises, then -> DATA with mem_rd issued; flash_io1_iosel stays 0.
- DATA:
  - Entering the state loads the shift register with mem_rdata.
  - Each fall pulse drives the next bit; flash_io1_iosel = 1 from the first fall in DATA.
  - On the fall that drives bit 7 of a byte, increment the address (mod 2^ADDR_W) and issue mem_rd. The returned byte goes into a next-byte register and transfers to the shift register after the 8th bit has been shifted.
  - Reading continues indefinitely until csb rises.
- ID: output the 3 JEDEC bytes, then 0x00 for every subsequent byte.
- IGNORE: io1 is not driven; wait for csb to rise.
- A synchronized csb rise from any state -> IDLE on the same cycle. It also clears iosel, the counters and the dummy flag, and drops any outstanding mem_rd.

## Timing
- Reset values: flash_io1_out=0, flash_io1_iosel=0, mem_rd=0, mem_addr=0, active=0, state=IDLE.
- Reset mid-transaction aborts the transaction. The block waits for a fresh csb fall; a transaction whose csb was already low at reset release is ignored until csb goes high.
- Edge-to-pulse latency is 3 clk (2 sync + 1 detect). A pad change lands ≤4 clk after a flash_clk fall.
- Requirement: flash_clk frequency ≤ clk/8 (half-period ≥ 4 clk). Then data is stable before the controller's next rising sample.
- mem_rd timing:
  - First byte: mem_rd 1 clk after the last address/dummy rise pulse; the shift register loads 2 clk after that rise pulse.
  - Later bytes: mem_rd is issued ≥ 7 fall pulses before the byte is needed.
- A byte in flight when csb rises is discarded. Address auto-increment carries across no boundary other than the 2^ADDR_W wrap.
- Simultaneous csb rise and a clk edge pulse: the csb rise wins.

## Test plan
- clk 16 MHz, flash_clk 2 MHz; send 0x9F then clock 32 bits -> io1 returns EF 40 16 00; iosel high from the first fall after the opcode.
- READ 0x03, address 0x000100, clock 4 bytes with memory[i]=i[7:0] -> returns 00 01 02 03; mem_rd pulses at addresses 0x100–0x103, each exactly 1 clk wide.
- FAST_READ 0x0B, address 0x000010, 8 dummy clocks -> iosel=0 during dummy; returns memory 0x10, 0x11.
- READ at 0xFFFFFE, clock 4 bytes -> addresses FFFFFE, FFFFFF, 000000, 000001 in order.
- Unknown opcode 0x05, clock 16 bits -> iosel stays 0 and mem_rd never fires. Then csb high; a following READ at 0x20 returns memory[0x20].
- csb raised after 12 address bits; then a new READ at 0x40 -> correct data. Separately, reset asserted mid-DATA -> all outputs return to reset values next cycle.
